uart_cmd_sched: RTL and testbench

Two-requester scheduler that shares one UART command master (24-bit command transmitter plus 8-bit response receiver) between independent command sources. It arbitrates round-robin, launches the granted requester's command, waits for the one-byte response, and retries on NAK or timeout up to a limit. It reports completion and status back to the owning requester. Sits between the requesters (e.g. host/test sequencer and autonomous poller) and the comm master.

---
 rtl/uart_cmd_sched.sv | 177 +++++++++++++++++
 tb/tb_uart_cmd_sched.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_sched.sv
// uart_cmd_sched
// Shares one UART command master between two requesters. Requests are
// arbitrated round-robin. The winner's 24-bit command is latched and launched,
// and its one-byte response is awaited. A NAK or a timeout causes a re-send,
// up to MAX_RETRY extra attempts, and the outcome is reported back to the
// owning requester.
//
// Ports
//   clk, rst_n     system clock, asynchronous active-low reset
//   req[1:0]       per-requester request level, held until its done pulse
//   cmd0, cmd1     per-requester 24-bit command, stable while requesting
//   gnt[1:0]       one-hot grant, high for the whole transaction
//   done[1:0]      one-cycle completion pulse to the granted requester
//   err            with done: 1 = retries exhausted, 0 = ACK received
//   rsp[7:0]       with done: last response byte (8'h00 after a timeout)
//   cmd[23:0]      latched command presented to the comm master
//   send_cmd       one-cycle launch pulse to the comm master
//   cmd_sent       comm master idle level (high when idle)
//   resp_rdy/resp  comm master response byte valid / value
//   clr_resp_rdy   one-cycle clear of the master's resp_rdy flag
module uart_cmd_sched #(
  parameter int          TIMEOUT   = 1_000_000,
  parameter int          MAX_RETRY = 2,
  parameter logic [7:0]  ACK       = 8'hA5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req,
  input  logic [23:0] cmd0,
  input  logic [23:0] cmd1,
  output logic [1:0]  gnt,
  output logic [1:0]  done,
  output logic        err,
  output logic [7:0]  rsp,
  output logic [23:0] cmd,
  output logic        send_cmd,
  input  logic        cmd_sent,
  input  logic        resp_rdy,
  input  logic [7:0]  resp,
  output logic        clr_resp_rdy
);

  localparam int CNT_W = $clog2(TIMEOUT) + 1;
  localparam int ATT_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [ATT_W-1:0] ATT_MAX  = ATT_W'(MAX_RETRY);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SEND    = 3'd1,
    ACCEPT  = 3'd2,
    TXWAIT  = 3'd3,
    RSPWAIT = 3'd4,
    FIN     = 3'd5
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   tmo_cnt;
  logic [ATT_W-1:0]   att_cnt;
  logic               last_ptr;   // requester served most recently
  logic               win;        // arbitration result in IDLE
  logic               rsp_ack;
  logic               att_fail;

  // Saturating increment for the response timeout counter.
  function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  // Round-robin pick: on a tie the requester not served last wins;
  // a lone request wins regardless of the pointer.
  function automatic logic pick_winner(input logic [1:0] r, input logic last);
    if (r == 2'b11) return ~last;
    return r[1];
  endfunction

  always_comb begin
    win      = pick_winner(req, last_ptr);
    rsp_ack  = 1'b0;
    att_fail = 1'b0;
    if (state == RSPWAIT) begin
      // A response in the timeout cycle takes precedence over the timeout.
      if (resp_rdy) begin
        rsp_ack  = (resp == ACK);
        att_fail = (resp != ACK);
      end else begin
        att_fail = (tmo_cnt == CNT_LAST);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      gnt          <= 2'b00;
      done         <= 2'b00;
      err          <= 1'b0;
      rsp          <= 8'h00;
      cmd          <= 24'h0;
      send_cmd     <= 1'b0;
      clr_resp_rdy <= 1'b0;
      tmo_cnt      <= '0;
      att_cnt      <= '0;
      last_ptr     <= 1'b1;
    end else begin
      send_cmd     <= 1'b0;
      clr_resp_rdy <= 1'b0;
      done         <= 2'b00;

      case (state)
        IDLE: begin
          if (|req) begin
            gnt          <= win ? 2'b10 : 2'b01;
            cmd          <= win ? cmd1 : cmd0;
            att_cnt      <= '0;
            send_cmd     <= 1'b1;
            clr_resp_rdy <= 1'b1;  // flush any stale response byte
            state        <= SEND;
          end
        end

        SEND: state <= ACCEPT;

        ACCEPT: begin
          if (!cmd_sent) state <= TXWAIT;
        end

        TXWAIT: begin
          if (cmd_sent) begin
            tmo_cnt <= '0;
            state   <= RSPWAIT;
          end
        end

        RSPWAIT: begin
          tmo_cnt <= cnt_sat_inc(tmo_cnt);
          if (resp_rdy) begin
            rsp          <= resp;
            clr_resp_rdy <= 1'b1;
          end else if (att_fail) begin
            rsp <= 8'h00;
          end

          if (rsp_ack) begin
            err   <= 1'b0;
            done  <= gnt;
            gnt   <= 2'b00;
            state <= FIN;
          end else if (att_fail) begin
            if (att_cnt < ATT_MAX) begin
              att_cnt      <= att_cnt + ATT_W'(1);
              send_cmd     <= 1'b1;
              clr_resp_rdy <= 1'b1;
              state        <= SEND;
            end else begin
              err   <= 1'b1;
              done  <= gnt;
              gnt   <= 2'b00;
              state <= FIN;
            end
          end
        end

        FIN: begin
          // done is visible this cycle; gnt already dropped.
          last_ptr <= done[1];
          state    <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_sched.sv
// tb_uart_cmd_sched
// Directed bench for uart_cmd_sched with a short TIMEOUT. The bench plays the
// comm master (cmd_sent handshake and response byte) and checks grants,
// launch pulses, latched commands, retry/timeout timing and completion status.
module tb_uart_cmd_sched;

  localparam int TIMEOUT   = 50;
  localparam int MAX_RETRY = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req = 2'b00;
  logic [23:0] cmd0 = 24'h0;
  logic [23:0] cmd1 = 24'h0;
  logic        cmd_sent = 1'b1;
  logic        resp_rdy = 1'b0;
  logic [7:0]  resp = 8'h00;

  logic [1:0]  gnt;
  logic [1:0]  done;
  logic        err;
  logic [7:0]  rsp;
  logic [23:0] cmd;
  logic        send_cmd;
  logic        clr_resp_rdy;

  int checks = 0;
  int errors = 0;

  uart_cmd_sched #(
    .TIMEOUT   (TIMEOUT),
    .MAX_RETRY (MAX_RETRY),
    .ACK       (8'hA5)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (req),
    .cmd0         (cmd0),
    .cmd1         (cmd1),
    .gnt          (gnt),
    .done         (done),
    .err          (err),
    .rsp          (rsp),
    .cmd          (cmd),
    .send_cmd     (send_cmd),
    .cmd_sent     (cmd_sent),
    .resp_rdy     (resp_rdy),
    .resp         (resp),
    .clr_resp_rdy (clr_resp_rdy)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for a launch pulse, then check the presented command and grant.
  task automatic wait_send(input string tag, input logic [23:0] exp_cmd, input logic [1:0] exp_gnt);
    int n = 0;
    while (send_cmd !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_send"}, 32'(send_cmd), 32'd1);
    chk({tag, "_cmd"}, 32'(cmd), 32'(exp_cmd));
    chk({tag, "_gnt"}, 32'(gnt), 32'(exp_gnt));
  endtask

  // Play one master attempt starting at the negedge where send_cmd is seen.
  // Response is presented to the scheduler when its counter equals d.
  task automatic attempt(input string tag, input logic [7:0] reply, input int d, input bit noresp);
    cmd_sent = 1'b0;
    repeat (3) @(negedge clk);
    cmd_sent = 1'b1;
    if (noresp) begin
      repeat (TIMEOUT) @(negedge clk);
      chk({tag, "_early"}, 32'({send_cmd, done}), 32'd0);
      @(negedge clk);
    end else begin
      repeat (d + 1) @(negedge clk);
      resp     = reply;
      resp_rdy = 1'b1;
      @(negedge clk);
      chk({tag, "_clr"}, 32'(clr_resp_rdy), 32'd1);
      resp_rdy = 1'b0;
    end
  endtask

  // Check completion at the current negedge, then the following idle cycle.
  task automatic end_txn(input string tag, input logic [1:0] exp_done, input logic exp_err,
                         input logic [7:0] exp_rsp, input logic [1:0] next_req);
    chk({tag, "_done"}, 32'(done), 32'(exp_done));
    chk({tag, "_err"}, 32'(err), 32'(exp_err));
    chk({tag, "_rsp"}, 32'(rsp), 32'(exp_rsp));
    chk({tag, "_gnt_drop"}, 32'(gnt), 32'd0);
    req = next_req;
    @(negedge clk);
    chk({tag, "_done_1cyc"}, 32'(done), 32'd0);
    chk({tag, "_gap"}, 32'({gnt, send_cmd}), 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = 2'b00;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    // Reset state
    @(negedge clk);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_rsp", 32'(rsp), 32'd0);
    chk("rst_cmd", 32'(cmd), 32'd0);
    chk("rst_send", 32'(send_cmd), 32'd0);
    chk("rst_clr", 32'(clr_resp_rdy), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single request, immediate ACK
    cmd0 = 24'h123456;
    req  = 2'b01;
    @(negedge clk);
    chk("t1_send_latency", 32'(send_cmd), 32'd1);
    chk("t1_clr_on_send", 32'(clr_resp_rdy), 32'd1);
    wait_send("t1", 24'h123456, 2'b01);
    attempt("t1", 8'hA5, 3, 1'b0);
    end_txn("t1", 2'b01, 1'b0, 8'hA5, 2'b00);

    // Simultaneous requests after reset: 0 first, then alternation
    do_reset();
    cmd0 = 24'h111111;
    cmd1 = 24'h222222;
    req  = 2'b11;
    wait_send("t2a", 24'h111111, 2'b01);
    attempt("t2a", 8'hA5, 0, 1'b0);
    end_txn("t2a", 2'b01, 1'b0, 8'hA5, 2'b11);
    wait_send("t2b", 24'h222222, 2'b10);
    attempt("t2b", 8'hA5, 1, 1'b0);
    end_txn("t2b", 2'b10, 1'b0, 8'hA5, 2'b11);
    wait_send("t2c", 24'h111111, 2'b01);
    attempt("t2c", 8'hA5, 2, 1'b0);
    end_txn("t2c", 2'b01, 1'b0, 8'hA5, 2'b00);

    // Two NAKs then ACK; cmd0 changed after grant must not matter
    cmd0 = 24'hABCDEF;
    req  = 2'b01;
    wait_send("t3a", 24'hABCDEF, 2'b01);
    cmd0 = 24'h000000;
    attempt("t3a", 8'h5A, 2, 1'b0);
    wait_send("t3b", 24'hABCDEF, 2'b01);
    attempt("t3b", 8'h5A, 5, 1'b0);
    wait_send("t3c", 24'hABCDEF, 2'b01);
    attempt("t3c", 8'hA5, 1, 1'b0);
    end_txn("t3", 2'b01, 1'b0, 8'hA5, 2'b00);

    // No response: three timed-out attempts, req dropped mid-transaction
    cmd1 = 24'h0F0F0F;
    req  = 2'b10;
    wait_send("t4a", 24'h0F0F0F, 2'b10);
    req = 2'b00;
    attempt("t4a", 8'h00, 0, 1'b1);
    wait_send("t4b", 24'h0F0F0F, 2'b10);
    attempt("t4b", 8'h00, 0, 1'b1);
    wait_send("t4c", 24'h0F0F0F, 2'b10);
    attempt("t4c", 8'h00, 0, 1'b1);
    end_txn("t4", 2'b10, 1'b1, 8'h00, 2'b00);

    // ACK exactly in the timeout cycle wins over the timeout
    cmd0 = 24'h5A5A5A;
    req  = 2'b01;
    wait_send("t5", 24'h5A5A5A, 2'b01);
    attempt("t5", 8'hA5, TIMEOUT - 1, 1'b0);
    chk("t5_no_resend", 32'(send_cmd), 32'd0);
    end_txn("t5", 2'b01, 1'b0, 8'hA5, 2'b00);

    // Reset during RSPWAIT, then priority restarts at requester 0
    cmd0 = 24'hC0FFEE;
    cmd1 = 24'hBEEF01;
    req  = 2'b11;
    wait_send("t6a", 24'hBEEF01, 2'b10);
    cmd_sent = 1'b0;
    repeat (3) @(negedge clk);
    cmd_sent = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_gnt", 32'(gnt), 32'd0);
    chk("t6_rst_send", 32'(send_cmd), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t6_rst_nodone", 32'(done), 32'd0);
    end
    rst_n = 1'b1;
    wait_send("t6b", 24'hC0FFEE, 2'b01);
    attempt("t6b", 8'hA5, 4, 1'b0);
    end_txn("t6b", 2'b01, 1'b0, 8'hA5, 2'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
